ft_mem_arbiter: RTL and testbench
=================================

# ft_mem_arbiter

Two-to-one arbiter that shares the single data-memory port of the dual-core SoC between core 1 and core 2. It accepts OBI-style request/grant/rvalid transactions from each core's data interface, grants the memory port round-robin, and tracks up to MAX_OUTSTANDING in-flight transactions so each read response is routed back to the issuing core. It sits between the two zeroriscy cores and the shared data RAM that holds the result and flag words.

## Interface
- ADDR_WIDTH, 32, address width of core and memory ports
- DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8
- MAX_OUTSTANDING, 2, maximum granted-but-not-responded transactions (power of two, ≥1)

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- core_req_i  in  2  request per core (bit 0 = core 1, bit 1 = core 2)
- core_gnt_o  out  2  grant per core
- core_rvalid_o  out  2  response valid per core
- core_addr_i  in  2×ADDR_WIDTH  request address per core
- core_we_i  in  2  write enable per core
- core_be_i  in  2×DATA_WIDTH/8  byte enables per core
- core_wdata_i  in  2×DATA_WIDTH  write data per core
- core_rdata_o  out  DATA_WIDTH  response data, shared, qualified by core_rvalid_o
- mem_req_o  out  1  request to memory
- mem_gnt_i  in  1  memory grant
- mem_rvalid_i  in  1  memory response valid
- mem_addr_o / mem_we_o / mem_be_o / mem_wdata_o  out  ADDR_WIDTH/1/DATA_WIDTH/8/DATA_WIDTH  selected request fields
- mem_rdata_i  in  DATA_WIDTH  memory response data
- err_o  out  1  sticky protocol error (rvalid with nothing outstanding)

## Operation
- Selection: if a request is locked, `sel` equals the locked owner. Otherwise, if only one core requests, that core is selected. If both request, the core named by rr_q is selected.
- mem_req_o = |core_req_i & ~full. The mem_* fields are muxed from `sel`.
- core_gnt_o[sel] = mem_req_o & mem_gnt_i. The other grant is 0.
- Lock: if mem_req_o=1 and mem_gnt_i=0, set lock_q=1 and owner_q=sel. Owner stays fixed until granted, so an OBI request is never withdrawn or switched mid-handshake. A grant clears the lock.
- Round-robin: on each grant, rr_q ← ~sel (the other core gets priority next time).
- ID FIFO: each grant pushes `sel`. Each mem_rvalid_i pops the head. core_rvalid_o[head]=mem_rvalid_i. core_rdata_o=mem_rdata_i, passed to both cores.
- full = (count_q == MAX_OUTSTANDING), using the registered count. When full, no request is issued, even if a pop happens in the same cycle.
- Push and pop in the same cycle leave count unchanged and update both pointers.
- mem_rvalid_i while the FIFO is empty: core_rvalid_o=0, err_o←1 (sticky until reset), count unchanged.
- Writes also occupy a FIFO slot. Their response (rvalid) is routed the same way.

## Timing
- Request to mem_req_o is combinational (0 cycles). Grant to core_gnt_o is combinational.
- Response routing is combinational from mem_rvalid_i and the registered FIFO head.
- Back-to-back grants to alternating cores are possible every cycle while not full.
- Reset values: rr_q=0 (core 1 favoured), lock_q=0, FIFO empty (count 0), err_o=0.
- Reset outputs: mem_req_o=0 and all core_gnt_o/core_rvalid_o=0, given mem_rvalid_i=0.
- Reset asserted mid-operation: all outstanding tracking is dropped immediately. Responses arriving after reset are treated as errors.

## Structure
- Package ft_mem_pkg: core_id_t (1-bit), NUM_CORES=2, and the request struct (addr, we, be, wdata).
- One sub-module, ft_id_fifo: a parameterised-depth FIFO holding core_id_t with push, pop, count, empty and full.
- The arbitration, lock and round-robin logic stays in ft_mem_arbiter.

## Test plan
- Core 1 alone: read of 0x100, mem_gnt_i=1 immediately, rvalid 1 cycle later with rdata 0xDEADBEEF → core_gnt_o=01 in cycle 0; core_rvalid_o=01 with 0xDEADBEEF in cycle 1; core_rvalid_o[1] never asserted.
- Both cores request continuously, memory always grants, rvalid 1 cycle after each grant → grants alternate 01,10,01,10 starting with core 1 after reset; each response goes to the matching core.
- Core 2 requests, mem_gnt_i held 0 for 3 cycles while core 1 also asserts → mem_addr_o stays core 2's address for all 3 cycles; core 2 is granted on cycle 4; core 1 is granted next.
- MAX_OUTSTANDING=2, two grants with no rvalid → mem_req_o=0 while requests are pending. One rvalid → count goes to 1, mem_req_o re-asserts the next cycle.
- mem_rvalid_i pulsed with nothing outstanding → err_o=1 and stays 1; no core_rvalid_o. rst_ni low → err_o=0.
- rst_ni pulsed low with 2 outstanding → count=0, rr_q=0, and mem_req_o follows core_req_i immediately after release.

Source files
------------

// File: rtl/ft_mem_pkg.sv
// Shared types for the dual-core data-memory arbiter.
// Core IDs, core count and the per-core request bundle.
package ft_mem_pkg;

    localparam int NUM_CORES = 2;
    localparam int REQ_AW    = 32;
    localparam int REQ_DW    = 32;

    typedef logic core_id_t;

    typedef struct packed {
        logic [REQ_AW-1:0]   addr;
        logic                we;
        logic [REQ_DW/8-1:0] be;
        logic [REQ_DW-1:0]   wdata;
    } mem_req_t;

endpackage

// File: rtl/ft_id_fifo.sv
// In-order FIFO of issuing core IDs for granted transactions.
// Head names the core that owns the next memory response.
module ft_id_fifo
    import ft_mem_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     push_i,
    input  logic     pop_i,
    input  core_id_t data_i,
    output core_id_t data_o,
    output logic     empty_o,
    output logic     full_o
);

    core_id_t        mem_q [DEPTH];
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [PW-1:0]   rptr_q, rptr_d;
    logic [CW-1:0]   count_q, count_d;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_i) begin
            wptr_d = (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + PW'(1);
        end
        if (pop_i) begin
            rptr_d = (rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + PW'(1);
        end
        if (push_i && !pop_i) begin
            count_d = count_q + CW'(1);
        end else if (!push_i && pop_i) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 1'b0;
            end
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            if (push_i) begin
                mem_q[wptr_q] <= data_i;
            end
        end
    end

    assign data_o  = mem_q[rptr_q];
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/ft_mem_arbiter.sv
// Round-robin 2:1 OBI arbiter for the shared data RAM.
// Holds a stalled request until granted; routes responses in order.
module ft_mem_arbiter
    import ft_mem_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [1:0]                   core_req_i,
    output logic [1:0]                   core_gnt_o,
    output logic [1:0]                   core_rvalid_o,
    input  logic [2*ADDR_WIDTH-1:0]      core_addr_i,
    input  logic [1:0]                   core_we_i,
    input  logic [2*DATA_WIDTH/8-1:0]    core_be_i,
    input  logic [2*DATA_WIDTH-1:0]      core_wdata_i,
    output logic [DATA_WIDTH-1:0]        core_rdata_o,
    output logic                         mem_req_o,
    input  logic                         mem_gnt_i,
    input  logic                         mem_rvalid_i,
    output logic [ADDR_WIDTH-1:0]        mem_addr_o,
    output logic                         mem_we_o,
    output logic [DATA_WIDTH/8-1:0]      mem_be_o,
    output logic [DATA_WIDTH-1:0]        mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]        mem_rdata_i,
    output logic                         err_o
);

    localparam int BW = DATA_WIDTH / 8;

    core_id_t sel;
    core_id_t rr_q, rr_d;
    core_id_t owner_q, owner_d;
    logic     lock_q, lock_d;
    logic     err_q, err_d;
    logic     full, empty, gnt, pop;
    core_id_t head;

    always_comb begin
        sel = rr_q;
        if (lock_q) begin
            sel = owner_q;
        end else if (core_req_i == 2'b01) begin
            sel = 1'b0;
        end else if (core_req_i == 2'b10) begin
            sel = 1'b1;
        end
    end

    assign mem_req_o   = |core_req_i & ~full;
    assign gnt         = mem_req_o & mem_gnt_i;
    assign core_gnt_o  = gnt ? (sel ? 2'b10 : 2'b01) : 2'b00;

    assign mem_addr_o  = sel ? core_addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH]
                             : core_addr_i[ADDR_WIDTH-1:0];
    assign mem_we_o    = sel ? core_we_i[1] : core_we_i[0];
    assign mem_be_o    = sel ? core_be_i[2*BW-1:BW] : core_be_i[BW-1:0];
    assign mem_wdata_o = sel ? core_wdata_i[2*DATA_WIDTH-1:DATA_WIDTH]
                             : core_wdata_i[DATA_WIDTH-1:0];

    // A stalled request keeps its owner so it is never switched mid-handshake.
    always_comb begin
        lock_d  = lock_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        if (gnt) begin
            lock_d = 1'b0;
            rr_d   = ~sel;
        end else if (mem_req_o) begin
            lock_d  = 1'b1;
            owner_d = sel;
        end
    end

    assign pop           = mem_rvalid_i & ~empty;
    assign err_d         = err_q | (mem_rvalid_i & empty);
    assign core_rvalid_o = pop ? (head ? 2'b10 : 2'b01) : 2'b00;
    assign core_rdata_o  = mem_rdata_i;
    assign err_o         = err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q    <= 1'b0;
            owner_q <= 1'b0;
            lock_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            rr_q    <= rr_d;
            owner_q <= owner_d;
            lock_q  <= lock_d;
            err_q   <= err_d;
        end
    end

    ft_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (gnt),
        .pop_i   (pop),
        .data_i  (sel),
        .data_o  (head),
        .empty_o (empty),
        .full_o  (full)
    );

endmodule

// File: tb/tb_ft_mem_arbiter.sv
// Directed scoreboard bench for ft_mem_arbiter.
// Expected responses are queued at grant time and checked on rvalid.
module tb_ft_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic [1:0]  core_req_i;
    logic [1:0]  core_gnt_o;
    logic [1:0]  core_rvalid_o;
    logic [63:0] core_addr_i;
    logic [1:0]  core_we_i;
    logic [7:0]  core_be_i;
    logic [63:0] core_wdata_i;
    logic [31:0] core_rdata_o;
    logic        mem_req_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_addr_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        err_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0]  rv;
        logic [31:0] d;
    } exp_t;

    exp_t sb [$];

    always #5 clk = ~clk;

    ft_mem_arbiter #(
        .ADDR_WIDTH      (32),
        .DATA_WIDTH      (32),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .core_req_i    (core_req_i),
        .core_gnt_o    (core_gnt_o),
        .core_rvalid_o (core_rvalid_o),
        .core_addr_i   (core_addr_i),
        .core_we_i     (core_we_i),
        .core_be_i     (core_be_i),
        .core_wdata_i  (core_wdata_i),
        .core_rdata_o  (core_rdata_o),
        .mem_req_o     (mem_req_o),
        .mem_gnt_i     (mem_gnt_i),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_addr_o    (mem_addr_o),
        .mem_we_o      (mem_we_o),
        .mem_be_o      (mem_be_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_rdata_i   (mem_rdata_i),
        .err_o         (err_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input string tag);
        exp_t e;
        total++;
        assert (sb.size() != 0) else begin
            bad++;
            $error("FAIL %s no expected entry observed=%0h expected=queued",
                   tag, core_rvalid_o);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_rv"}, 64'(core_rvalid_o), 64'(e.rv));
            chk({tag, "_rd"}, 64'(core_rdata_o), 64'(e.d));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_ni       = 1'b0;
        core_req_i   = 2'b00;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        tick();
        rst_ni = 1'b1;
        sb.delete();
    endtask

    initial begin
        rst_ni       = 1'b0;
        core_req_i   = 2'b00;
        core_addr_i  = {32'h0000_0200, 32'h0000_0100};
        core_we_i    = 2'b00;
        core_be_i    = 8'hF0;
        core_wdata_i = {32'h1234_5678, 32'h0BAD_F00D};
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'h0;

        // reset state
        @(negedge clk);
        chk("rst_req", 64'(mem_req_o), 64'd0);
        chk("rst_gnt", 64'(core_gnt_o), 64'd0);
        chk("rst_rv", 64'(core_rvalid_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        tick();
        rst_ni = 1'b1;

        // core 1 alone, read 0x100
        core_req_i = 2'b01;
        mem_gnt_i  = 1'b1;
        @(negedge clk);
        chk("t1_gnt", 64'(core_gnt_o), 64'h1);
        chk("t1_req", 64'(mem_req_o), 64'h1);
        chk("t1_addr", 64'(mem_addr_o), 64'h100);
        chk("t1_we", 64'(mem_we_o), 64'h0);
        sb.push_back('{2'b01, 32'hDEAD_BEEF});
        tick();
        core_req_i   = 2'b00;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hDEAD_BEEF;
        @(negedge clk);
        pop_chk("t1_resp");
        tick();
        mem_rvalid_i = 1'b0;

        // both cores continuously, alternating grants
        do_reset();
        for (int i = 0; i < 5; i++) begin
            core_req_i   = (i < 4) ? 2'b11 : 2'b00;
            mem_gnt_i    = (i < 4);
            mem_rvalid_i = (i > 0);
            mem_rdata_i  = 32'hA0 + 32'(i) - 32'd1;
            @(negedge clk);
            if (i > 0) pop_chk($sformatf("t2_resp%0d", i));
            if (i < 4) begin
                chk($sformatf("t2_gnt%0d", i), 64'(core_gnt_o),
                    (i % 2 == 0) ? 64'h1 : 64'h2);
                chk($sformatf("t2_addr%0d", i), 64'(mem_addr_o),
                    (i % 2 == 0) ? 64'h100 : 64'h200);
                sb.push_back('{(i % 2 == 0) ? 2'b01 : 2'b10, 32'hA0 + 32'(i)});
            end
            tick();
        end
        mem_rvalid_i = 1'b0;

        // core 2 write stalled 3 cycles while core 1 joins
        do_reset();
        core_we_i  = 2'b10;
        core_req_i = 2'b10;
        mem_gnt_i  = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) core_req_i = 2'b11;
            @(negedge clk);
            chk($sformatf("t3_stall_gnt%0d", c), 64'(core_gnt_o), 64'h0);
            chk($sformatf("t3_stall_addr%0d", c), 64'(mem_addr_o), 64'h200);
            tick();
        end
        mem_gnt_i = 1'b1;
        @(negedge clk);
        chk("t3_gnt2", 64'(core_gnt_o), 64'h2);
        chk("t3_we", 64'(mem_we_o), 64'h1);
        chk("t3_be", 64'(mem_be_o), 64'hF);
        chk("t3_wdata", 64'(mem_wdata_o), 64'h1234_5678);
        sb.push_back('{2'b10, 32'h0});
        tick();
        core_req_i = 2'b01;
        @(negedge clk);
        chk("t3_gnt1", 64'(core_gnt_o), 64'h1);
        chk("t3_addr1", 64'(mem_addr_o), 64'h100);
        sb.push_back('{2'b01, 32'h11});
        tick();

        // full: two outstanding blocks further requests
        core_req_i = 2'b11;
        @(negedge clk);
        chk("t4_full_req", 64'(mem_req_o), 64'h0);
        chk("t4_full_gnt", 64'(core_gnt_o), 64'h0);
        tick();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h0;
        @(negedge clk);
        pop_chk("t4_resp_w");
        chk("t4_pop_req", 64'(mem_req_o), 64'h0);
        tick();
        mem_rvalid_i = 1'b0;
        @(negedge clk);
        chk("t4_rearm_req", 64'(mem_req_o), 64'h1);
        chk("t4_rearm_gnt", 64'(core_gnt_o), 64'h2);
        sb.push_back('{2'b10, 32'h22});
        tick();
        core_req_i   = 2'b00;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h11;
        @(negedge clk);
        pop_chk("t4_resp_c1");
        tick();
        mem_rdata_i = 32'h22;
        @(negedge clk);
        pop_chk("t4_resp_c2");
        tick();

        // rvalid with nothing outstanding
        mem_rdata_i = 32'h5;
        @(negedge clk);
        chk("t5_rv", 64'(core_rvalid_o), 64'h0);
        chk("t5_err0", 64'(err_o), 64'h0);
        tick();
        mem_rvalid_i = 1'b0;
        @(negedge clk);
        chk("t5_err1", 64'(err_o), 64'h1);
        tick();
        @(negedge clk);
        chk("t5_err_sticky", 64'(err_o), 64'h1);
        tick();
        rst_ni = 1'b0;
        @(negedge clk);
        chk("t5_err_rst", 64'(err_o), 64'h0);
        tick();
        rst_ni = 1'b1;

        // reset with two outstanding drops tracking
        core_we_i  = 2'b00;
        core_req_i = 2'b11;
        mem_gnt_i  = 1'b1;
        @(negedge clk);
        chk("t6_gnt_a", 64'(core_gnt_o), 64'h1);
        tick();
        @(negedge clk);
        chk("t6_gnt_b", 64'(core_gnt_o), 64'h2);
        tick();
        mem_gnt_i = 1'b0;
        rst_ni    = 1'b0;
        @(negedge clk);
        chk("t6_rst_req", 64'(mem_req_o), 64'h1);
        tick();
        rst_ni    = 1'b1;
        mem_gnt_i = 1'b1;
        @(negedge clk);
        chk("t6_post_req", 64'(mem_req_o), 64'h1);
        chk("t6_post_gnt", 64'(core_gnt_o), 64'h1);
        sb.push_back('{2'b01, 32'h33});
        tick();
        core_req_i   = 2'b00;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h33;
        @(negedge clk);
        pop_chk("t6_resp");
        tick();
        @(negedge clk);
        chk("t6_stale_rv", 64'(core_rvalid_o), 64'h0);
        tick();
        mem_rvalid_i = 1'b0;
        @(negedge clk);
        chk("t6_stale_err", 64'(err_o), 64'h1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
